// File: rtl/register_pkg.sv
// Shared types for the general register file.
// Holds access sizes, lane masks and register names.
package register_pkg;

  typedef enum logic [1:0] {
    SIZE_8  = 2'd0,
    SIZE_16 = 2'd1,
    SIZE_32 = 2'd2
  } access_size_t;

  localparam int EAX = 0;
  localparam int EBX = 1;
  localparam int ECX = 2;
  localparam int EDX = 3;
  localparam int ESI = 4;
  localparam int EDI = 5;
  localparam int EBP = 6;
  localparam int ESP = 7;

  // Byte lanes touched by an access; high selects the 15:8 alias.
  function automatic logic [3:0] lane_mask(
    input access_size_t size,
    input logic         high
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      size == SIZE_8:  m = high ? 4'b0010 : 4'b0001;
      size == SIZE_16: m = 4'b0011;
      size == SIZE_32: m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/register_read_port.sv
// One read port of the register file.
// Extracts the sized field and registers the response.
module register_read_port
  import register_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         accept,
  input  access_size_t size,
  input  logic         high,
  input  logic [31:0]  word,
  output logic         rsp_valid,
  output logic [31:0]  rsp_data
);

  logic [31:0] data;

  // Zero-extend the selected field of the source word.
  always_comb begin
    data = '0;
    unique case (1'b1)
      size == SIZE_8:  data[7:0]  = high ? word[15:8] : word[7:0];
      size == SIZE_16: data[15:0] = word[15:0];
      default:         data       = word;
    endcase
  end

  // Response one cycle after accept; data holds between reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept)
        rsp_data <= data;
    end
  end

endmodule

// File: rtl/general_register_file.sv
// Multi-port register file with busy scoreboard.
// Byte-lane merged writes are forwarded to same-cycle reads.
module general_register_file
  import register_pkg::*;
#(
  parameter int REG_COUNT   = 8,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  localparam int IW = $clog2(REG_COUNT)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           wr_valid     [WRITE_PORTS],
  input  logic [IW-1:0]  wr_index     [WRITE_PORTS],
  input  access_size_t   wr_size      [WRITE_PORTS],
  input  logic [31:0]    wr_data      [WRITE_PORTS],
  input  logic           wr_release   [WRITE_PORTS],
  input  logic           rd_req_valid [READ_PORTS],
  output logic           rd_req_ready [READ_PORTS],
  input  logic [IW-1:0]  rd_index     [READ_PORTS],
  input  access_size_t   rd_size      [READ_PORTS],
  output logic           rd_rsp_valid [READ_PORTS],
  output logic [31:0]    rd_rsp_data  [READ_PORTS],
  input  logic           rsv_valid,
  input  logic [IW-1:0]  rsv_index,
  output logic           rsv_ready,
  output logic [REG_COUNT-1:0] busy
);

  function automatic logic in_range(input logic [IW-1:0] idx);
    return int'(idx) < REG_COUNT;
  endfunction

  function automatic logic high_byte(
    input access_size_t s,
    input logic [IW-1:0] idx
  );
    return s == SIZE_8 && int'(idx) >= 4 && int'(idx) < 8;
  endfunction

  function automatic logic [IW-1:0] map_index(
    input access_size_t s,
    input logic [IW-1:0] idx
  );
    return high_byte(s, idx) ? (idx & ~IW'(4)) : idx;
  endfunction

  logic [31:0]          regs      [REG_COUNT];
  logic [31:0]          regs_next [REG_COUNT];
  logic [3:0]           w_mask    [WRITE_PORTS];
  logic [31:0]          w_data    [WRITE_PORTS];
  logic [IW-1:0]        w_phys    [WRITE_PORTS];
  logic [REG_COUNT-1:0] release_hit;
  logic [REG_COUNT-1:0] busy_next;

  // Per-port lane mask, target register and lane-aligned data.
  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      w_phys[p] = map_index(wr_size[p], wr_index[p]);
      w_mask[p] = (wr_valid[p] && in_range(wr_index[p]))
                ? lane_mask(wr_size[p],
                            high_byte(wr_size[p], wr_index[p]))
                : 4'b0000;
      w_data[p] = high_byte(wr_size[p], wr_index[p])
                ? {wr_data[p][23:0], 8'h00}
                : wr_data[p];
    end
  end

  // Lane merge; later (higher) ports overwrite earlier ones.
  always_comb begin
    regs_next = regs;
    for (int p = 0; p < WRITE_PORTS; p++)
      for (int b = 0; b < 4; b++)
        if (w_mask[p][b])
          regs_next[w_phys[p]][b*8 +: 8] = w_data[p][b*8 +: 8];
  end

  // Registers released by a write this cycle.
  always_comb begin
    release_hit = '0;
    for (int p = 0; p < WRITE_PORTS; p++)
      if (wr_valid[p] && wr_release[p] && in_range(wr_index[p]))
        release_hit[wr_index[p]] = 1'b1;
  end

  assign rsv_ready = !in_range(rsv_index) ||
                     !busy[rsv_index] ||
                     release_hit[rsv_index];

  // Release first, then reserve, so a same-cycle pair stays busy.
  always_comb begin
    busy_next = busy & ~release_hit;
    if (rsv_valid && rsv_ready && in_range(rsv_index))
      busy_next[rsv_index] = 1'b1;
  end

  // Storage and scoreboard state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      regs <= regs_next;
      busy <= busy_next;
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic        ok;
    logic        hi;
    logic [31:0] word;

    assign ok   = in_range(rd_index[i]);
    assign hi   = high_byte(rd_size[i], rd_index[i]);
    assign word = ok ? regs_next[map_index(rd_size[i], rd_index[i])]
                     : 32'h0;

    assign rd_req_ready[i] = !ok || !busy[rd_index[i]] ||
                             release_hit[rd_index[i]];

    register_read_port u_port (
      .clock     (clock),
      .reset     (reset),
      .accept    (rd_req_valid[i] && rd_req_ready[i]),
      .size      (rd_size[i]),
      .high      (hi),
      .word      (word),
      .rsp_valid (rd_rsp_valid[i]),
      .rsp_data  (rd_rsp_data[i])
    );
  end

endmodule

// File: doc/general_register_file.md
GENERAL_REGISTER_FILE -- requirements
Module: general_register_file

Interface
REQ-001 The block SHALL take parameter REG_COUNT, default 8, giving the number of architectural registers; the minimum value is 4.
REQ-002 The block SHALL take parameter READ_PORTS, default 2, giving the number of independent read ports.
REQ-003 The block SHALL take parameter WRITE_PORTS, default 2, giving the number of write ports; a higher port number has higher priority.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: clock  input  1  rising-edge clock; reset  input  1  asynchronous, active-low (0 = reset).
REQ-005 The block SHALL provide the per-write-port inputs wr_valid[WRITE_PORTS] (1), wr_index (clog2 REG_COUNT), wr_size (access_size_t), wr_data (32) and wr_release (1, clears busy).
REQ-006 The block SHALL provide the per-read-port signals rd_req_valid (in, 1), rd_req_ready (out, 1), rd_index (in), rd_size (in, access_size_t), rd_rsp_valid (out, 1) and rd_rsp_data (out, 32).
REQ-007 The block SHALL provide a single reservation port: rsv_valid (in, 1), rsv_index (in), rsv_ready (out, 1).
REQ-008 The block SHALL provide busy (out, REG_COUNT), the current scoreboard bits.

Function
REQ-009 access_size_t SHALL be SIZE_8, SIZE_16 or SIZE_32.
REQ-010 SIZE_32 writes SHALL update bits 31:0.
REQ-011 SIZE_16 writes SHALL update bits 15:0 only.
REQ-012 SIZE_8 writes with index 0-3 SHALL update bits 7:0 of registers 0-3.
REQ-013 SIZE_8 writes with index 4-7 SHALL update bits 15:8 of registers 0-3 from wr_data[7:0].
REQ-014 Write-data byte placement SHALL always be from the low bits of wr_data.
REQ-015 Writes SHALL take effect at the clock edge where wr_valid=1; no write handshake exists.
REQ-016 For simultaneous writes to one register, the result SHALL be merged per byte lane, with the highest-numbered port that writes a lane winning that lane.
REQ-017 A read request SHALL be accepted when rd_req_valid=1 and rd_req_ready=1.
REQ-018 An accepted read SHALL produce rd_rsp_valid=1 exactly one cycle later, with rd_rsp_data zero-extended to 32 bits per size: SIZE_8 index 4-7 returns bits 15:8 of registers 0-3 in [7:0], and SIZE_16 returns [15:0].
REQ-019 rd_rsp_valid SHALL be 0 in cycles following no acceptance, and rd_rsp_data SHALL hold its last value.
REQ-020 Read data SHALL include same-cycle writes: a request accepted in the same cycle as a write to that register returns the post-write, lane-merged value.
REQ-021 rd_req_ready SHALL be combinational and equal to !busy[rd_index] || (some wr_valid with wr_release=1 targets rd_index this cycle).
REQ-022 rsv_ready SHALL be !busy[rsv_index] || (a release to rsv_index this cycle).
REQ-023 busy[rsv_index] SHALL be set on rsv_valid && rsv_ready.
REQ-024 A write with wr_release=1 SHALL clear busy[wr_index].
REQ-025 When a reserve and a release of the same register occur in one cycle, busy SHALL end up 1.
REQ-026 A release of a non-busy register SHALL be harmless.
REQ-027 An index >= REG_COUNT SHALL be ignored on writes and reservations, and SHALL read as 0 with ready=1.
REQ-028 A SIZE_8 access with index >= 4 on a register outside 0-3 SHALL NOT occur; the mapping is fixed to registers 0-3.

Reset
REQ-029 While reset=0, all registers, busy, rd_rsp_valid and rd_rsp_data SHALL be 0, asynchronously.
REQ-030 A read accepted in the cycle reset asserts SHALL produce no response.
REQ-031 The first accepted read SHALL be possible in the first rising clock edge after reset deasserts.

Structure
REQ-032 access_size_t, the byte-lane-mask function and register-index constants (EAX=0 ... ESP=7) SHALL reside in a shared package, register_pkg.
REQ-033 One sub-module, register_read_port (size extraction plus output register), SHALL be instantiated READ_PORTS times.
REQ-034 Storage and lane merge SHALL stay in the top level.

Verification
REQ-035 The bench SHALL check: write port0 idx0 SIZE_32 0x12345678, then SIZE_8 idx4 data 0xAB -> read SIZE_32 idx0 returns 0x1234AB78, and read SIZE_8 idx4 returns 0x000000AB one cycle after accept.
REQ-036 The bench SHALL check: same cycle, port0 idx2 SIZE_32 0xFFFFFFFF and port1 idx2 SIZE_16 0x0000 -> reg2 = 0xFFFF0000.
REQ-037 The bench SHALL check: reserve idx3, then read idx3 -> rd_req_ready=0; a write idx3 0x55 with wr_release in the next cycle -> ready=1 that cycle and response 0x00000055.
REQ-038 The bench SHALL check: reserve and release idx1 in the same cycle -> busy[1]=1 afterward.
REQ-039 The bench SHALL check: with regs loaded, busy set and a read in flight, assert reset=0 mid-cycle -> all outputs 0 immediately, and no stale rd_rsp_valid after release.
REQ-040 The bench SHALL check: READ_PORTS=4 and REG_COUNT=16 -> four parallel reads of distinct registers all return correct values with 1-cycle latency.
